// File: rtl/led_scan_pkg.sv
// led_scan_pkg: shared types, geometry constants and the frame row-extract
// helper used by the LED matrix row-scan driver.
// Optional feature macro used by the driver: LED_SCAN_DIM_EN.
package led_scan_pkg;

  // Scan FSM: BLANK holds all rows/columns off, DRIVE lights one row.
  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_e;

  localparam int NUM_ROWS = 8;
  localparam int NUM_COLS = 8;
  localparam int FRAME_W  = NUM_ROWS * NUM_COLS;

  // Frame bit index is {y[2:0], x[2:0]}, so row y occupies bits y*8 +: 8.
  function automatic logic [NUM_COLS-1:0] pix_to_row(
    input logic [FRAME_W-1:0] frame,
    input logic [2:0]         row
  );
    return frame[{row, 3'b000} +: NUM_COLS];
  endfunction

endpackage

// File: rtl/led_scan_frame_buf.sv
// led_scan_frame_buf: pending/active double buffer for the LED matrix.
// Captures a new frame into the pending buffer whenever pix_valid is high,
// and promotes pending to active only on the frame-boundary swap strobe so
// the displayed image never tears.  A capture that coincides with the swap
// strobe lands in pending after the old pending frame has been promoted.
module led_scan_frame_buf
  import led_scan_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [FRAME_W-1:0] pix,
  input  logic               pix_valid,
  input  logic               swap,
  output logic [FRAME_W-1:0] active,
  output logic               pend
);

  logic [FRAME_W-1:0] r_pending;
  logic [FRAME_W-1:0] r_active;
  logic               r_pend;
  logic               w_promote;

  // A swap strobe only changes the display when an unshown frame exists.
  assign w_promote = swap & r_pend;

  // Capture/swap arbitration: promotion reads the old pending value, a
  // same-edge capture overwrites pending and keeps the pending flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
      r_active  <= '0;
      r_pend    <= 1'b0;
    end else begin
      if (w_promote) begin
        r_active <= r_pending;
      end
      if (pix_valid) begin
        r_pending <= pix;
        r_pend    <= 1'b1;
      end else if (w_promote) begin
        r_pend    <= 1'b0;
      end
    end
  end

  assign active = r_active;
  assign pend   = r_pend;

endmodule

// File: rtl/led_matrix_scan.sv
// led_matrix_scan: row-scan driver for the 8x8 LED matrix.
// Each row slot is BLANK_CYCLES all-off cycles followed by ROW_DWELL cycles
// driving one-hot row_en and that row's column bits from the active frame.
// Rows advance 0..7 and wrap; the frame buffer swaps on the row7->row0 edge.
// Optional feature: define LED_SCAN_DIM_EN to add the 2-bit dim input, which
// gates col to the first (dim+1)/4 of each DRIVE dwell (row_en stays on).
// Parameter constraints: ROW_DWELL >= 4 (multiple of 4 with dimming),
// BLANK_CYCLES >= 1.
//
// Handshake: pix_valid is a one-sided strobe with no ready; every cycle it is
// high at a clock edge, pix is accepted into the pending buffer.
//
// Counter meaning: r_state/r_row/r_dwell describe the cycle currently shown on
// the outputs.  Outputs are registered from the next-state values so that they
// always line up with the state registers.  r_run is clear only during the
// first edge after reset, which enters row 0 BLANK and raises frame_start.
module led_matrix_scan
  import led_scan_pkg::*;
#(
  parameter int ROW_DWELL    = 16,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [FRAME_W-1:0]  pix,
  input  logic                pix_valid,
`ifdef LED_SCAN_DIM_EN
  input  logic [1:0]          dim,
`endif
  output logic [NUM_ROWS-1:0] row_en,
  output logic [NUM_COLS-1:0] col,
  output logic                frame_start,
  output logic                pend,
  output scan_state_e         dbg_state
);

  localparam int MAX_CNT = (ROW_DWELL > BLANK_CYCLES) ? ROW_DWELL : BLANK_CYCLES;
  localparam int DW_W    = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
  localparam logic [DW_W-1:0] DRIVE_LAST = DW_W'(ROW_DWELL - 1);
  localparam logic [DW_W-1:0] BLANK_LAST = DW_W'(BLANK_CYCLES - 1);

  scan_state_e          r_state;
  scan_state_e          w_n_state;
  logic [2:0]           r_row;
  logic [2:0]           w_n_row;
  logic [DW_W-1:0]      r_dwell;
  logic [DW_W-1:0]      w_n_dwell;
  logic                 r_run;
  logic                 w_swap;
  logic                 w_lit;
  logic [FRAME_W-1:0]   w_active;
  logic                 w_pend;
  logic [NUM_ROWS-1:0]  r_row_en;
  logic [NUM_COLS-1:0]  r_col;
  logic                 r_frame_start;

  // Next scan position: advance the dwell counter, flip state at the end of
  // each phase, and step the row when a DRIVE phase ends.
  always_comb begin
    w_n_state = r_state;
    w_n_row   = r_row;
    w_n_dwell = r_dwell;
    if (r_run) begin
      case (r_state)
        BLANK: begin
          if (r_dwell == BLANK_LAST) begin
            w_n_state = DRIVE;
            w_n_dwell = '0;
          end else begin
            w_n_dwell = r_dwell + 1'b1;
          end
        end
        DRIVE: begin
          if (r_dwell == DRIVE_LAST) begin
            w_n_state = BLANK;
            w_n_row   = r_row + 3'd1;
            w_n_dwell = '0;
          end else begin
            w_n_dwell = r_dwell + 1'b1;
          end
        end
        default: begin
          w_n_state = BLANK;
          w_n_row   = 3'd0;
          w_n_dwell = '0;
        end
      endcase
    end
  end

  // The frame boundary is the edge leaving the last DRIVE cycle of row 7.
  assign w_swap = r_run && (r_state == DRIVE) && (r_row == 3'd7) &&
                  (r_dwell == DRIVE_LAST);

`ifdef LED_SCAN_DIM_EN
  localparam int QUARTER = ROW_DWELL / 4;
  logic [31:0] w_lit_limit;

  // Dimming: columns are lit only for the first (dim+1) quarters of DRIVE.
  always_comb begin
    w_lit_limit = ({30'd0, dim} + 32'd1) * 32'(QUARTER);
    w_lit       = ({{(32-DW_W){1'b0}}, w_n_dwell} < w_lit_limit);
  end
`else
  assign w_lit = 1'b1;
`endif

  led_scan_frame_buf u_frame_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .pix       (pix),
    .pix_valid (pix_valid),
    .swap      (w_swap),
    .active    (w_active),
    .pend      (w_pend)
  );

  // Scan FSM with registered outputs decoded from the position being entered.
  // Active only changes on the swap edge, which always enters BLANK, so the
  // current active frame is the right source for the next DRIVE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= BLANK;
      r_row         <= 3'd0;
      r_dwell       <= '0;
      r_run         <= 1'b0;
      r_row_en      <= '0;
      r_col         <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_run         <= 1'b1;
      r_state       <= w_n_state;
      r_row         <= w_n_row;
      r_dwell       <= w_n_dwell;
      r_row_en      <= (w_n_state == DRIVE) ? (NUM_ROWS'(1) << w_n_row) : '0;
      r_col         <= ((w_n_state == DRIVE) && w_lit) ?
                       pix_to_row(w_active, w_n_row) : '0;
      r_frame_start <= (w_n_state == BLANK) && (w_n_row == 3'd0) &&
                       (w_n_dwell == '0);
    end
  end

  assign row_en      = r_row_en;
  assign col         = r_col;
  assign frame_start = r_frame_start;
  assign pend        = w_pend;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_led_matrix_scan.sv
// tb_led_matrix_scan: scoreboard bench for led_matrix_scan with
// ROW_DWELL=4, BLANK_CYCLES=1 (40-cycle frame).  Define LED_SCAN_DIM_EN to
// exercise the dimming build.
`timescale 1ns/1ps
module tb_led_matrix_scan;
  import led_scan_pkg::*;

  localparam int RD     = 4;
  localparam int BC     = 1;
  localparam int SLOT   = RD + BC;
  localparam int PERIOD = 8 * SLOT;
  localparam int W      = 19;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] pix = '0;
  logic        pix_valid = 1'b0;
`ifdef LED_SCAN_DIM_EN
  logic [1:0]  dim = 2'd3;
`endif
  logic [7:0]  row_en;
  logic [7:0]  col;
  logic        frame_start;
  logic        pend;
  scan_state_e dbg_state;

  always #5 clk = ~clk;

  led_matrix_scan #(
    .ROW_DWELL    (RD),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pix         (pix),
    .pix_valid   (pix_valid),
`ifdef LED_SCAN_DIM_EN
    .dim         (dim),
`endif
    .row_en      (row_en),
    .col         (col),
    .frame_start (frame_start),
    .pend        (pend),
    .dbg_state   (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: cycle index since reset release plus the two frames.
  logic [63:0] m_active  = '0;
  logic [63:0] m_pending = '0;
  logic        m_pend    = 1'b0;
  int          m_cnt     = 0;

  // Apply the edge about to happen to the model and queue the outputs that
  // the cycle following that edge must show.
  task automatic model_push(input logic v, input logic [63:0] p);
    int pos, row, off;
    logic lit;
    logic [7:0] re, cc;
    if (m_cnt > 0 && (m_cnt % PERIOD) == 0 && m_pend) begin
      m_active = m_pending;
      m_pend   = 1'b0;
    end
    if (v) begin
      m_pending = p;
      m_pend    = 1'b1;
    end
    pos = m_cnt % PERIOD;
    row = pos / SLOT;
    off = pos % SLOT;
    lit = 1'b1;
`ifdef LED_SCAN_DIM_EN
    lit = (off - BC) < ((int'(dim) + 1) * RD / 4);
`endif
    if (off < BC) begin
      re = 8'h00;
      cc = 8'h00;
    end else begin
      re = 8'(1 << row);
      cc = lit ? m_active[row*8 +: 8] : 8'h00;
    end
    exp_q.push_back({(pos == 0), m_pend, (off >= BC), re, cc});
    m_cnt++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_now(input logic v, input logic [63:0] p);
    pix_valid = v;
    pix       = v ? p : {$urandom(), $urandom()};
    model_push(v, p);
  endtask

  task automatic step(input logic v, input logic [63:0] p);
    @(negedge clk);
    drive_now(v, p);
  endtask

  task automatic advance_to(input int n);
    while (m_cnt < n) step(1'b0, 64'h0);
  endtask

  task automatic check_reset_outputs(input string tag);
    #1;
    checks++;
    if ({frame_start, pend, (dbg_state == DRIVE), row_en, col} !== '0) begin
      errors++;
      $display("FAIL %s: got fs=%0b pend=%0b drv=%0b row_en=%02h col=%02h, expected all zero",
               tag, frame_start, pend, (dbg_state == DRIVE), row_en, col);
    end
  endtask

  task automatic model_reset();
    m_active  = '0;
    m_pending = '0;
    m_pend    = 1'b0;
    m_cnt     = 0;
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [W-1:0] e;
    logic [W-1:0] a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {frame_start, pend, (dbg_state == DRIVE), row_en, col};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL scan t=%0t: got fs=%0b pend=%0b drv=%0b row_en=%02h col=%02h, expected fs=%0b pend=%0b drv=%0b row_en=%02h col=%02h",
                   $time, a[18], a[17], a[16], a[15:8], a[7:0],
                   e[18], e[17], e[16], e[15:8], e[7:0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [63:0] r;
    logic        v;

    // Reset state.
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_state");

    // Release: first cycle is row 0 BLANK with frame_start.
    @(negedge clk);
    rst_n = 1'b1;
    drive_now(1'b0, 64'h0);

    // Idle scan through frame 0 and into frame 1; corner pixels in frame 1.
    advance_to(50);
    step(1'b1, 64'h8000_0000_0000_0001);
    advance_to(130);

    // Two captures in one frame: last write wins.
    step(1'b1, 64'h0000_0000_0000_00FF);
    advance_to(140);
    step(1'b1, 64'h0000_0000_0000_FF00);
    advance_to(170);

    // Capture exactly on the swap edge while a frame is pending.
    step(1'b1, 64'h1);
    advance_to(200);
    step(1'b1, 64'h2);
    advance_to(290);

    // Randomized captures (and brightness when dimming is built in).
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
`ifdef LED_SCAN_DIM_EN
      dim = 2'($urandom_range(0, 3));
`endif
      v = ($urandom_range(0, 19) == 0);
      r = {$urandom(), $urandom()};
      drive_now(v, r);
    end
`ifdef LED_SCAN_DIM_EN
    @(negedge clk);
    dim = 2'd1;
    drive_now(1'b1, 64'h0000_0000_0000_00FF);
    advance_to(m_cnt + 2 * PERIOD);
    dim = 2'd3;
`endif

    // Reset during row 4 DRIVE with a frame pending: pending is lost.
    while ((m_cnt % PERIOD) != 5) step(1'b0, 64'h0);
    step(1'b1, {$urandom(), $urandom()} | 64'h1);
    while ((m_cnt % PERIOD) != 23) step(1'b0, 64'h0);
    @(negedge clk);
    rst_n = 1'b0;
    pix_valid = 1'b0;
    model_reset();
    check_reset_outputs("reset_mid_row4");
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_at_reset: got %0d entries, expected 0", exp_q.size());
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drive_now(1'b0, 64'h0);
    advance_to(2 * PERIOD + 3);

    // Scan resumes normally after the mid-frame reset.
    r = {$urandom(), $urandom()};
    step(1'b1, r);
    advance_to(m_cnt + 3 * PERIOD);

    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d entries left, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
